// File: rtl/uio_bus_arbiter.sv
// uio_bus_arbiter
//   Shares the bidirectional uio[7:0] pad bus between two requesters (A, B).
//   Each transaction is a single byte: write (drive uio_out) or read (sample
//   uio_in). Turnaround cycles are inserted on a bus direction change, and the
//   winner gets a one-cycle ack. Read data is returned on rdata.
//
//   Ports:
//     clk, rst_n                  clock, asynchronous active-low reset
//     req_a/we_a/wdata_a, ack_a   requester A: level request, direction, byte, ack pulse
//     req_b/we_b/wdata_b, ack_b   requester B: same as A
//     rdata                       last byte read, valid from the ack cycle onwards
//     busy                        high whenever the FSM is not idle
//     uio_in/uio_out/uio_oe       pad input, pad output, pad output enable
//
//   Optional feature: define UIO_ARB_FIXED_PRIO_EN to give A fixed priority
//   over B. When it is undefined, arbitration is round-robin.
module uio_bus_arbiter #(
  parameter int unsigned TURN_CYCLES = 1,
  parameter int unsigned XFER_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_a,
  input  logic       we_a,
  input  logic [7:0] wdata_a,
  output logic       ack_a,
  input  logic       req_b,
  input  logic       we_b,
  input  logic [7:0] wdata_b,
  output logic       ack_b,
  output logic [7:0] rdata,
  output logic       busy,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int unsigned CNT_W = 3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TURN = 2'd1,
    S_XFER = 2'd2,
    S_ACK  = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               dir_q, dir_d;       // 1 = bus driven (output)
  logic               win_b_q, win_b_d;   // latched winner, 1 = B
  logic               we_q, we_d;
  logic [7:0]         wdata_q, wdata_d;
`ifndef UIO_ARB_FIXED_PRIO_EN
  logic               last_b_q, last_b_d; // 1 = last grant went to B
`endif

  logic [7:0]         oe_q, oe_d;
  logic [7:0]         out_q, out_d;
  logic               ack_a_q, ack_a_d;
  logic               ack_b_q, ack_b_d;
  logic [7:0]         rdata_q, rdata_d;
  logic               busy_q, busy_d;

  logic               gnt_b_c;

  // Arbitration: which requester would be granted if sampled now
`ifdef UIO_ARB_FIXED_PRIO_EN
  assign gnt_b_c = req_b && !req_a;
`else
  assign gnt_b_c = req_b && (!req_a || !last_b_q);
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dir_q    <= 1'b0;
      win_b_q  <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= 8'h00;
`ifndef UIO_ARB_FIXED_PRIO_EN
      last_b_q <= 1'b1;
`endif
      oe_q     <= 8'h00;
      out_q    <= 8'h00;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      rdata_q  <= 8'h00;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dir_q    <= dir_d;
      win_b_q  <= win_b_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
`ifndef UIO_ARB_FIXED_PRIO_EN
      last_b_q <= last_b_d;
`endif
      oe_q     <= oe_d;
      out_q    <= out_d;
      ack_a_q  <= ack_a_d;
      ack_b_q  <= ack_b_d;
      rdata_q  <= rdata_d;
      busy_q   <= busy_d;
    end
  end

  // Next-state logic: grant, turnaround and transfer sequencing
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    win_b_d  = win_b_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
`ifndef UIO_ARB_FIXED_PRIO_EN
    last_b_d = last_b_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          win_b_d  = gnt_b_c;
          we_d     = gnt_b_c ? we_b : we_a;
          wdata_d  = gnt_b_c ? wdata_b : wdata_a;
`ifndef UIO_ARB_FIXED_PRIO_EN
          last_b_d = gnt_b_c;
`endif
          if (we_d != dir_q) begin
            state_d = S_TURN;
            cnt_d   = CNT_W'(TURN_CYCLES - 1);
          end else begin
            state_d = S_XFER;
            cnt_d   = CNT_W'(XFER_CYCLES - 1);
          end
        end
      end
      S_TURN: begin
        if (cnt_q == '0) begin
          state_d = S_XFER;
          cnt_d   = CNT_W'(XFER_CYCLES - 1);
          dir_d   = we_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_XFER: begin
        if (cnt_q == '0) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Output logic: outputs for the coming cycle, derived from the next state
  always_comb begin
    oe_d    = 8'h00;
    out_d   = out_q;
    ack_a_d = 1'b0;
    ack_b_d = 1'b0;
    rdata_d = rdata_q;
    busy_d  = (state_d != S_IDLE);

    // Read byte is captured at the end of the last transfer cycle
    if ((state_q == S_XFER) && (cnt_q == '0) && !we_q) begin
      rdata_d = uio_in;
    end

    unique case (state_d)
      S_IDLE: oe_d = {8{dir_d}};
      S_TURN: oe_d = 8'h00;
      S_XFER: begin
        oe_d = {8{we_d}};
        if (we_d) begin
          out_d = wdata_d;
        end
      end
      S_ACK: begin
        oe_d    = {8{dir_d}};
        ack_a_d = !win_b_d;
        ack_b_d = win_b_d;
      end
      default: oe_d = 8'h00;
    endcase
  end

  assign uio_oe  = oe_q;
  assign uio_out = out_q;
  assign ack_a   = ack_a_q;
  assign ack_b   = ack_b_q;
  assign rdata   = rdata_q;
  assign busy    = busy_q;

endmodule

// File: doc/uio_bus_arbiter.md
Name: uio_bus_arbiter

Overview:
- Shares the bidirectional uio[7:0] pad bus of the tt_um top level between two internal requesters, A and B.
- Each requester issues single-byte write (drive) or read (sample) transactions.
- Block arbitrates between them, inserts bus turnaround cycles on direction changes, sequences uio_oe/uio_out, and returns read data with a one-cycle ack.

Parameters:
- TURN_CYCLES, 1: idle cycles with uio_oe=0 inserted on any bus direction change (legal range 1..7).
- XFER_CYCLES, 2: cycles a transfer occupies the bus (legal range 1..7).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- req_a  input  1  requester A transaction request (level)
- we_a  input  1  A direction: 1=write/drive, 0=read
- wdata_a  input  8  A write byte
- ack_a  output  1  one-cycle completion pulse to A
- req_b  input  1  requester B transaction request (level)
- we_b  input  1  B direction
- wdata_b  input  8  B write byte
- ack_b  output  1  one-cycle completion pulse to B
- rdata  output  8  read byte; valid in the ack cycle, held until the next read completes
- busy  output  1  high in every state except IDLE
- uio_in  input  8  pad input path
- uio_out  output  8  pad output path
- uio_oe  output  8  pad output enable (1=drive)

Behaviour:
- Reset (async, rst_n=0) forces immediately:
  - uio_oe=8'h00, uio_out=8'h00, ack_a=ack_b=0, rdata=8'h00, busy=0.
  - state=IDLE, bus_dir=input.
  - last_grant=B, so A wins the first tie.
- FSM states: IDLE, TURN, XFER, ACK.
- IDLE:
  - On a sampled req, latch winner, we and wdata.
  - If latched we differs from bus_dir: go to TURN. Otherwise go to XFER.
  - Only the latched copies are used after the grant; requesters need not hold wdata past the grant edge.
- TURN:
  - uio_oe=8'h00 for exactly TURN_CYCLES cycles.
  - Then bus_dir is updated to the latched we, and the FSM goes to XFER.
- XFER:
  - Write: uio_out=latched wdata, uio_oe=8'hFF for XFER_CYCLES cycles.
  - Read: uio_oe=8'h00 for XFER_CYCLES cycles; uio_in is sampled into rdata at the end of the last XFER cycle.
- ACK: the winner's ack is high for exactly one cycle, then the FSM returns to IDLE.
- Latency from a req sampled in IDLE (cycle n):
  - ack in cycle n+1+XFER_CYCLES when no turnaround is needed.
  - ack in cycle n+1+TURN_CYCLES+XFER_CYCLES when a turnaround is needed.
- Bus hold: between transactions, uio_oe reflects bus_dir (8'hFF after a write, 8'h00 after a read) and uio_out holds the last written byte.
- Arbitration:
  - Only one requester pending: it wins.
  - Both pending: the one not in last_grant wins (round-robin).
  - last_grant updates at grant.
- Handshake:
  - req is a level; the requester drops it at the same edge where it samples ack=1.
  - A req still high in the IDLE cycle after ACK starts a new transaction.
- Req dropped mid-transaction: the transaction completes and ack still pulses.
- Requests arriving in TURN, XFER or ACK wait; they are sampled only in IDLE.
- ack_a and ack_b are never high together.
- uio_oe is always all-0 or all-1.
- Internal counters are 3 bits wide; they are loaded with parameter-1 and count down.

Optional Feature:
- Macro: UIO_ARB_FIXED_PRIO_EN.
- Defined: A always wins when both requesters are pending; last_grant is unused.
- Undefined: round-robin as described under Behaviour.

Test Plan:
All scenarios use TURN_CYCLES=1, XFER_CYCLES=2.
1. Reset, hold rst_n=0 with random inputs -> uio_oe=00, uio_out=00, rdata=00, ack_a=ack_b=0, busy=0. Assert rst_n=0 mid-XFER -> uio_oe=00 in the same cycle, no ack.
2. After reset, req_a=1, we_a=1, wdata_a=A5 sampled at cycle 0:
   - cycle 1: TURN, uio_oe=00.
   - cycles 2-3: uio_oe=FF, uio_out=A5.
   - cycle 4: ack_a=1.
   - afterwards: uio_oe stays FF, uio_out stays A5.
3. Next, req_b read with uio_in=3C at cycle m:
   - cycle m+1: TURN, uio_oe=00.
   - cycles m+2..m+3: uio_oe=00.
   - cycle m+4: ack_b=1, rdata=3C.
4. Back-to-back A writes 11 then 22 with no direction change -> no TURN; acks at n+3 and n+7; uio_out changes 11->22 with uio_oe=FF throughout.
5. req_a and req_b (both writes) held together after reset -> grant order A,B,A,B, and acks alternate. With UIO_ARB_FIXED_PRIO_EN defined -> order A,A,A while req_a is kept asserted.
6. Drop req_b one cycle after its grant -> transaction completes, ack_b still pulses at the expected cycle, then busy=0.
